rc_measure_sequencer: RTL and testbench

Sequences the RC charge/discharge excitation for the resistance-measurement datapath. The block drives the RC step output, times each charge until the comparator input rises, and discharges for a fixed period. It repeats this for 2^LOG2_AVG samples and presents the averaged charge time to the downstream resistance calculator over a valid/ready handshake. It sits between the chip top-level pins (step output, comparator input) and the arithmetic stage.

---
 rtl/rc_tdc_pkg.sv | 15 +
 rtl/rc_input_sync.sv | 20 ++
 rtl/rc_measure_sequencer.sv | 153 +++++++++++++++
 tb/tb_rc_measure_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rc_tdc_pkg.sv
// Shared types and defaults for the RC time-to-digital measurement blocks.
package rc_tdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE_DIS,
    CHARGE,
    DISCHARGE,
    REPORT
  } rc_state_e;

  localparam int CNT_W_DEF    = 24;
  localparam int LOG2_AVG_DEF = 2;

endpackage

// File: rtl/rc_input_sync.sv
// Multi-flop synchronizer for asynchronous pin inputs; clears to 0 on reset.
module rc_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], din};
  end

  assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rc_measure_sequencer.sv
// RC charge/discharge sequencer: times charges to the comparator trip point,
// averages 2^LOG2_AVG samples and hands the result downstream via valid/ready.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for start, excitation off
// PRE_DIS   | initial discharge before the first charge of a measurement
// CHARGE    | step_set high, counting cycles until the comparator trips
// DISCHARGE | step_set low between samples, minimum DISCHARGE_CYCLES
// REPORT    | averaged result held with result_valid until accepted
module rc_measure_sequencer
  import rc_tdc_pkg::*;
#(
  parameter int               CNT_W            = CNT_W_DEF,
  parameter int               LOG2_AVG         = LOG2_AVG_DEF,
  parameter int               DISCHARGE_CYCLES = 1000,
  parameter logic [CNT_W-1:0] TIMEOUT          = {CNT_W{1'b1}},
  parameter int               SYNC_STAGES      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             step_input,
  output logic             step_set,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             timeout_err
);

  localparam int               ACC_W    = CNT_W + LOG2_AVG;
  localparam int               IDX_W    = LOG2_AVG + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << LOG2_AVG) - 1);
  localparam logic [CNT_W-1:0] DIS_LAST = CNT_W'(DISCHARGE_CYCLES - 1);

  rc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             terr_q, terr_d;
  logic             step_q, step_d;
  logic             sin;

  rc_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (step_input),
    .dout (sin)
  );

  assign acc_sum = acc_q + ACC_W'(cnt_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    valid_d  = valid_q;
    terr_d   = terr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = PRE_DIS;
          terr_d  = 1'b0;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      PRE_DIS, DISCHARGE: begin
        if (cnt_q >= DIS_LAST && !sin) begin
          state_d = CHARGE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT) begin
          state_d = IDLE;
          terr_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      CHARGE: begin
        if (sin) begin
          acc_d = acc_sum;
          idx_d = idx_q + 1'b1;
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d  = REPORT;
            result_d = acc_sum[ACC_W-1:LOG2_AVG];
            valid_d  = 1'b1;
          end else begin
            state_d = DISCHARGE;
          end
        end else if (cnt_q == TIMEOUT) begin
          state_d = IDLE;
          terr_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      REPORT: begin
        cnt_d = '0;
        if (result_ready) begin
          valid_d = 1'b0;
          if (continuous) begin
            state_d = PRE_DIS;
            acc_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Registered so the pin is glitch-free and still drops asynchronously on reset.
    step_d = (state_d == CHARGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      terr_q   <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      terr_q   <= terr_d;
      step_q   <= step_d;
    end
  end

  assign step_set     = step_q;
  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign result_valid = valid_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_rc_measure_sequencer.sv
// Directed bench: three sequencer instances (single sample, 4-sample average,
// short timeout) sharing one clock and reset.
module tb_rc_measure_sequencer;

  localparam int CW  = 24;
  localparam int LIM = 2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start [3];
  logic          continuous [3];
  logic          step_input [3];
  logic          result_ready [3];
  logic          step_set [3];
  logic          busy [3];
  logic          result_valid [3];
  logic          timeout_err [3];
  logic [CW-1:0] result [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rc_measure_sequencer #(.CNT_W(CW), .LOG2_AVG(0), .DISCHARGE_CYCLES(8),
                         .TIMEOUT(24'd200), .SYNC_STAGES(2)) u_single (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .continuous(continuous[0]),
    .step_input(step_input[0]), .step_set(step_set[0]), .busy(busy[0]),
    .result(result[0]), .result_valid(result_valid[0]),
    .result_ready(result_ready[0]), .timeout_err(timeout_err[0]));

  rc_measure_sequencer #(.CNT_W(CW), .LOG2_AVG(2), .DISCHARGE_CYCLES(8),
                         .TIMEOUT(24'd200), .SYNC_STAGES(2)) u_avg (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .continuous(continuous[1]),
    .step_input(step_input[1]), .step_set(step_set[1]), .busy(busy[1]),
    .result(result[1]), .result_valid(result_valid[1]),
    .result_ready(result_ready[1]), .timeout_err(timeout_err[1]));

  rc_measure_sequencer #(.CNT_W(CW), .LOG2_AVG(0), .DISCHARGE_CYCLES(8),
                         .TIMEOUT(24'd50), .SYNC_STAGES(2)) u_tmo (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .continuous(continuous[2]),
    .step_input(step_input[2]), .step_set(step_set[2]), .busy(busy[2]),
    .result(result[2]), .result_valid(result_valid[2]),
    .result_ready(result_ready[2]), .timeout_err(timeout_err[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_step(input int i, input logic lvl, input string tag);
    int n = 0;
    while (step_set[i] !== lvl && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk(tag, step_set[i], lvl);
  endtask

  task automatic wait_valid(input int i, input string tag);
    int n = 0;
    while (result_valid[i] !== 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk(tag, result_valid[i], 1);
  endtask

  // Comparator trips 'delay' clocks after step_set rises; released once step_set falls.
  task automatic charge(input int i, input int delay, input string tag);
    wait_step(i, 1'b1, {tag, "_rise"});
    repeat (delay) @(posedge clk);
    #1 step_input[i] = 1'b1;
    @(negedge clk);
    wait_step(i, 1'b0, {tag, "_fall"});
    step_input[i] = 1'b0;
  endtask

  task automatic handshake(input int i);
    result_ready[i] = 1'b1;
    @(negedge clk);
    result_ready[i] = 1'b0;
  endtask

  // Low cycles from the first discharge cycle until step_set rises again.
  task automatic gap_len(input int i, output int n);
    n = 0;
    while (step_set[i] === 1'b0 && n < LIM) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int   delays [4];
    int   n;
    logic seen;
    logic stable;

    delays = '{100, 101, 102, 105};
    for (int k = 0; k < 3; k++) begin
      start[k]        = 1'b0;
      continuous[k]   = 1'b0;
      step_input[k]   = 1'b0;
      result_ready[k] = 1'b0;
    end

    repeat (3) @(negedge clk);
    chk("rst_step_set", step_set[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_result", result[0], 0);
    chk("rst_valid", result_valid[0], 0);
    chk("rst_terr", timeout_err[0], 0);
    rst_n = 1'b1;

    // single sample: 100 + 2 synchronizer cycles
    pulse_start(0);
    chk("t1_busy", busy[0], 1);
    chk("t1_predis_low", step_set[0], 0);
    charge(0, 100, "t1");
    wait_valid(0, "t1_valid");
    chk("t1_result", result[0], 102);
    chk("t1_terr", timeout_err[0], 0);
    start[0] = 1'b1;
    handshake(0);
    start[0] = 1'b0;
    chk("t1_valid_drop", result_valid[0], 0);
    chk("t1_idle", busy[0], 0);
    chk("t1_result_kept", result[0], 102);

    // four-sample average: (102+103+104+107)>>2 = 104
    pulse_start(1);
    for (int k = 0; k < 4; k++) begin
      charge(1, delays[k], "t2");
      if (k < 3) begin
        gap_len(1, n);
        chk("t2_gap", n, 8);
      end
    end
    wait_valid(1, "t2_valid");
    chk("t2_result", result[1], 104);
    chk("t2_terr", timeout_err[1], 0);
    handshake(1);
    chk("t2_idle", busy[1], 0);

    // charge timeout: comparator never trips, 51 charge cycles then abort
    pulse_start(2);
    wait_step(2, 1'b1, "t3_rise");
    n = 0;
    seen = 1'b0;
    while (step_set[2] === 1'b1 && n < LIM) begin
      n++;
      seen |= result_valid[2];
      @(negedge clk);
    end
    chk("t3_charge_len", n, 51);
    chk("t3_terr", timeout_err[2], 1);
    chk("t3_idle", busy[2], 0);
    chk("t3_no_valid", seen | result_valid[2], 0);
    pulse_start(2);
    chk("t3_terr_clear", timeout_err[2], 0);
    chk("t3_busy", busy[2], 1);
    n = 0;
    while (busy[2] === 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("t3_rerun_done", busy[2], 0);

    // comparator stuck high: stays in pre-discharge until timeout
    step_input[2] = 1'b1;
    repeat (3) @(negedge clk);
    pulse_start(2);
    n = 0;
    seen = 1'b0;
    while (busy[2] === 1'b1 && n < LIM) begin
      n++;
      seen |= step_set[2];
      @(negedge clk);
    end
    chk("t4_busy_len", n, 51);
    chk("t4_never_charged", seen, 0);
    chk("t4_terr", timeout_err[2], 1);
    step_input[2] = 1'b0;

    // backpressure with continuous mode
    continuous[0] = 1'b1;
    pulse_start(0);
    charge(0, 20, "t5");
    wait_valid(0, "t5_valid");
    chk("t5_result", result[0], 22);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      stable &= (result[0] == 22) && result_valid[0] && !step_set[0] && busy[0];
    end
    chk("t5_stall_stable", stable, 1);
    handshake(0);
    chk("t5_valid_drop", result_valid[0], 0);
    chk("t5_restart_busy", busy[0], 1);
    gap_len(0, n);
    chk("t5_restart_gap", n, 8);
    continuous[0] = 1'b0;
    charge(0, 30, "t5b");
    wait_valid(0, "t5b_valid");
    chk("t5b_result", result[0], 32);
    handshake(0);
    chk("t5b_idle", busy[0], 0);

    // asynchronous reset in the middle of a charge
    pulse_start(0);
    wait_step(0, 1'b1, "t6_rise");
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_step_set", step_set[0], 0);
    chk("t6_busy", busy[0], 0);
    chk("t6_result", result[0], 0);
    chk("t6_valid", result_valid[0], 0);
    chk("t6_terr_other", timeout_err[2], 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(0);
    charge(0, 40, "t6b");
    wait_valid(0, "t6b_valid");
    chk("t6b_result", result[0], 42);
    handshake(0);
    chk("t6b_idle", busy[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
